// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the core execute stage and data memory.
// Decodes RV funct3 into byte-lane masks, replicates store data across the bus,
// shifts and sign/zero-extends load data, flags misaligned/illegal requests,
// and reports bus errors and timeouts. One outstanding access at a time.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               core request (valid/ready, we, funct3, addr, wdata, rd)
//   resp_*              one-cycle completion pulse with data, rd and error code
//                       (00 ok, 01 illegal/misaligned, 10 bus error, 11 timeout)
//   busy                high in every state except IDLE
//   mem_req_*/mem_*     memory request channel (addr word-aligned, wdata, wmask)
//   mem_resp_*/mem_rdata memory response channel, sampled only while waiting
module mem_access_unit #(
  parameter int XLEN        = 64,
  parameter int ADDR_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [4:0]        resp_rd,
  output logic [1:0]        resp_err,
  output logic              busy,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp_err
);

  localparam int BYTES  = XLEN / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic [TW-1:0]     timer;
  logic [XLEN-1:0]   rdata_q;
  logic [1:0]        err_q;

  logic [1:0]        size_q;
  logic [LANE_W-1:0] lane;
  logic              req_illegal;
  logic              timeout_hit;
  logic [BYTES-1:0]  base_mask;
  logic [XLEN-1:0]   wdata_rep;
  logic [XLEN-1:0]   load_shifted;
  logic [XLEN-1:0]   load_ext;

  assign size_q = f3_q[1:0];
  assign lane   = addr_q[LANE_W-1:0];

  // Request legality, evaluated on the raw inputs in the accept cycle.
  always_comb begin
    logic [2:0] amask;
    amask = '0;
    case (req_funct3[1:0])
      2'd0: amask = 3'b000;
      2'd1: amask = 3'b001;
      2'd2: amask = 3'b011;
      default: amask = 3'b111;
    endcase
    req_illegal = ((req_addr[2:0] & amask) != 3'b000)
                | ((XLEN == 32) && ((req_funct3[1:0] == 2'd3) || (req_funct3 == 3'b110)))
                | (req_we && req_funct3[2]);
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer == TLIM);

  // Lane mask and store replication are built per byte so the same code
  // serves both bus widths without zero-width replications.
  always_comb begin
    int unsigned nbytes;
    nbytes    = 32'd1 << size_q;
    base_mask = '0;
    wdata_rep = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      base_mask[i]        = (i < nbytes);
      wdata_rep[8*i +: 8] = wdata_q[8*(i % nbytes) +: 8];
    end
  end

  always_comb begin
    int unsigned nbits;
    int unsigned sidx;
    logic        sbit;
    load_shifted = mem_rdata >> {lane, 3'b000};
    nbits        = 32'd8 << size_q;
    sidx         = (nbits > XLEN) ? XLEN - 1 : nbits - 1;
    sbit         = !f3_q[2] && load_shifted[sidx];
    load_ext     = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      load_ext[i] = (i < nbits) ? load_shifted[i] : sbit;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; timeout takes priority over a same-cycle handshake/response
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = req_illegal ? RESP : REQ;
      REQ: begin
        if (timeout_hit)        state_nxt = RESP;
        else if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (timeout_hit)         state_nxt = RESP;
        else if (mem_resp_valid) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, timer and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      timer   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rd_q    <= req_rd;
          timer   <= '0;
          rdata_q <= '0;
          err_q   <= req_illegal ? 2'b01 : 2'b00;
        end
        REQ, WAIT: begin
          timer <= timer + TW'(1);
          if (timeout_hit) begin
            err_q   <= 2'b11;
            rdata_q <= '0;
          end else if (state == WAIT && mem_resp_valid) begin
            err_q   <= mem_resp_err ? 2'b10 : 2'b00;
            rdata_q <= (mem_resp_err || we_q) ? '0 : load_ext;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    req_ready     = (state == IDLE);
    busy          = (state != IDLE);
    mem_req_valid = (state == REQ);
    mem_we        = (state == REQ) && we_q;
    mem_wmask     = ((state == REQ) && we_q) ? (base_mask << lane) : '0;
    mem_addr      = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    mem_wdata     = wdata_rep;
    resp_valid    = (state == RESP);
    resp_rdata    = (state == RESP) ? rdata_q : '0;
    resp_err      = (state == RESP) ? err_q : 2'b00;
    resp_rd       = rd_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic        busy, mem_req_valid, mem_req_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;
  logic        mem_resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(64), .ADDR_W(64), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
    .busy(busy), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  // Transaction record filled by do_access
  int          t_lat, t_nreq;
  logic [63:0] t_rdata, t_maddr, t_mwdata;
  logic [1:0]  t_err;
  logic [4:0]  t_rd;
  logic [7:0]  t_mwmask;
  logic        t_mwe, t_rdy, t_pulse2;

  // Issues one request starting at a negedge in IDLE and acts as memory:
  // responds in the cycle after the handshake. 'stray' drives mem_resp_valid
  // in every non-WAIT cycle. Ends on the negedge after the response pulse.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [4:0] rd,
                           input logic [63:0] mrdata, input logic merr,
                           input logic mready, input logic stray);
    logic hs;
    hs = 1'b0; t_lat = -1; t_nreq = 0; t_rdata = 'x; t_err = 'x; t_rd = 'x;
    t_maddr = '0; t_mwdata = '0; t_mwmask = '0; t_mwe = 1'b0; t_pulse2 = 1'bx;
    t_rdy = req_ready;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = rd; mem_req_ready = mready;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_rdata = '0;
      if (hs) begin
        mem_resp_valid = 1'b1; mem_rdata = mrdata; mem_resp_err = merr; hs = 1'b0;
      end else if (stray) begin
        mem_resp_valid = 1'b1; mem_resp_err = 1'b0; mem_rdata = '1;
      end
      if (mem_req_valid) begin
        t_nreq++;
        t_maddr = mem_addr; t_mwdata = mem_wdata; t_mwmask = mem_wmask; t_mwe = mem_we;
        if (mem_req_ready) hs = 1'b1;
      end
      if (resp_valid) begin
        t_lat = c; t_rdata = resp_rdata; t_err = resp_err; t_rd = resp_rd;
        break;
      end
    end
    if (t_lat < 0) begin
      errors++;
      $display("FAIL access_timeout: no resp_valid within 20 cycles");
    end
    @(negedge clk);
    t_pulse2 = resp_valid;
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_req_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if ({mem_we, mem_wmask, resp_err} !== 11'd0) begin errors++; $display("FAIL rst_we_mask_err: got %h expected 0", {mem_we, mem_wmask, resp_err}); end
    checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", resp_rdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got ready=%b busy=%b expected 1/0", req_ready, busy); end
  endtask

  task automatic test_loads;
    // lb, byte 3 = 0x80 -> sign-extended
    do_access(1'b0, 3'b000, 64'h80001003, 64'd0, 5'd7, 64'h00000000_80000000, 1'b0, 1'b1, 1'b0);
    checks++; if (t_rdy !== 1'b1) begin errors++; $display("FAIL lb_ready: got %b expected 1", t_rdy); end
    checks++; if (t_lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", t_lat); end
    checks++; if (t_rdata !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h expected FFFFFFFFFFFFFF80", t_rdata); end
    checks++; if (t_err !== 2'b00) begin errors++; $display("FAIL lb_err: got %b expected 00", t_err); end
    checks++; if (t_rd !== 5'd7) begin errors++; $display("FAIL lb_rd: got %0d expected 7", t_rd); end
    checks++; if (t_maddr !== 64'h80001000) begin errors++; $display("FAIL lb_mem_addr: got %h expected 80001000", t_maddr); end
    checks++; if (t_mwe !== 1'b0 || t_mwmask !== 8'h00) begin errors++; $display("FAIL lb_we_mask: got we=%b mask=%h expected 0/00", t_mwe, t_mwmask); end
    checks++; if (t_pulse2 !== 1'b0) begin errors++; $display("FAIL lb_one_pulse: got %b expected 0", t_pulse2); end
    // lwu / lw on upper word
    do_access(1'b0, 3'b110, 64'h80001004, 64'd0, 5'd9, 64'hDEADBEEF_00000000, 1'b0, 1'b1, 1'b0);
    checks++; if (t_rdata !== 64'h00000000DEADBEEF) begin errors++; $display("FAIL lwu_rdata: got %h expected 00000000DEADBEEF", t_rdata); end
    do_access(1'b0, 3'b010, 64'h80001004, 64'd0, 5'd9, 64'hDEADBEEF_00000000, 1'b0, 1'b1, 1'b0);
    checks++; if (t_rdata !== 64'hFFFFFFFFDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h expected FFFFFFFFDEADBEEF", t_rdata); end
    // lh lane 4 negative, lhu lane 6, lbu lane 1
    do_access(1'b0, 3'b001, 64'h80001004, 64'd0, 5'd1, 64'h00008000_00000000, 1'b0, 1'b1, 1'b0);
    checks++; if (t_rdata !== 64'hFFFFFFFFFFFF8000) begin errors++; $display("FAIL lh_rdata: got %h expected FFFFFFFFFFFF8000", t_rdata); end
    do_access(1'b0, 3'b101, 64'h80001006, 64'd0, 5'd2, 64'hFFEE0000_00000000, 1'b0, 1'b1, 1'b0);
    checks++; if (t_rdata !== 64'h000000000000FFEE) begin errors++; $display("FAIL lhu_rdata: got %h expected FFEE", t_rdata); end
    do_access(1'b0, 3'b100, 64'h80001001, 64'd0, 5'd3, 64'h00000000_0000FF00, 1'b0, 1'b1, 1'b0);
    checks++; if (t_rdata !== 64'h00000000000000FF) begin errors++; $display("FAIL lbu_rdata: got %h expected FF", t_rdata); end
  endtask

  task automatic test_stores;
    do_access(1'b1, 3'b001, 64'h80001006, 64'hFFFFFFFF_FFFF1234, 5'd4, 64'hAAAAAAAA_AAAAAAAA, 1'b0, 1'b1, 1'b0);
    checks++; if (t_maddr !== 64'h80001000) begin errors++; $display("FAIL sh_mem_addr: got %h expected 80001000", t_maddr); end
    checks++; if (t_mwmask !== 8'hC0) begin errors++; $display("FAIL sh_wmask: got %h expected C0", t_mwmask); end
    checks++; if (t_mwdata !== 64'h1234123412341234) begin errors++; $display("FAIL sh_wdata: got %h expected 1234123412341234", t_mwdata); end
    checks++; if (t_mwe !== 1'b1) begin errors++; $display("FAIL sh_we: got %b expected 1", t_mwe); end
    checks++; if (t_rdata !== 64'd0 || t_err !== 2'b00) begin errors++; $display("FAIL sh_resp: got rdata=%h err=%b expected 0/00", t_rdata, t_err); end
    do_access(1'b1, 3'b000, 64'h80001005, 64'h00000000_000000AB, 5'd4, 64'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (t_mwmask !== 8'h20 || t_mwdata !== 64'hABABABABABABABAB) begin errors++; $display("FAIL sb_mask_data: got %h/%h expected 20/ABABABABABABABAB", t_mwmask, t_mwdata); end
    do_access(1'b1, 3'b010, 64'h8000100C, 64'h11111111_CAFEF00D, 5'd4, 64'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (t_mwmask !== 8'hF0 || t_mwdata !== 64'hCAFEF00D_CAFEF00D || t_maddr !== 64'h80001008) begin errors++; $display("FAIL sw_mask_data_addr: got %h/%h/%h expected F0/CAFEF00DCAFEF00D/80001008", t_mwmask, t_mwdata, t_maddr); end
    do_access(1'b1, 3'b011, 64'h80001008, 64'h01234567_89ABCDEF, 5'd4, 64'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (t_mwmask !== 8'hFF || t_mwdata !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL sd_mask_data: got %h/%h expected FF/0123456789ABCDEF", t_mwmask, t_mwdata); end
  endtask

  task automatic test_illegal;
    do_access(1'b1, 3'b010, 64'h80001002, 64'h55, 5'd6, 64'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (t_lat !== 1) begin errors++; $display("FAIL sw_mis_latency: got %0d expected 1", t_lat); end
    checks++; if (t_err !== 2'b01) begin errors++; $display("FAIL sw_mis_err: got %b expected 01", t_err); end
    checks++; if (t_nreq !== 0) begin errors++; $display("FAIL sw_mis_no_bus: got %0d mem requests expected 0", t_nreq); end
    checks++; if (t_rdata !== 64'd0 || t_rd !== 5'd6) begin errors++; $display("FAIL sw_mis_resp: got rdata=%h rd=%0d expected 0/6", t_rdata, t_rd); end
    do_access(1'b0, 3'b011, 64'h80001004, 64'd0, 5'd6, 64'hFFFF, 1'b0, 1'b1, 1'b0);
    checks++; if (t_err !== 2'b01 || t_nreq !== 0) begin errors++; $display("FAIL ld_mis: got err=%b nreq=%0d expected 01/0", t_err, t_nreq); end
    do_access(1'b0, 3'b101, 64'h80001001, 64'd0, 5'd6, 64'hFFFF, 1'b0, 1'b1, 1'b0);
    checks++; if (t_err !== 2'b01 || t_nreq !== 0) begin errors++; $display("FAIL lhu_mis: got err=%b nreq=%0d expected 01/0", t_err, t_nreq); end
    do_access(1'b1, 3'b100, 64'h80001000, 64'd1, 5'd6, 64'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (t_err !== 2'b01 || t_nreq !== 0) begin errors++; $display("FAIL store_unsigned: got err=%b nreq=%0d expected 01/0", t_err, t_nreq); end
  endtask

  task automatic test_bus_error;
    do_access(1'b0, 3'b010, 64'h80001000, 64'd0, 5'd12, 64'h12345678_9ABCDEF0, 1'b1, 1'b1, 1'b0);
    checks++; if (t_err !== 2'b10 || t_rdata !== 64'd0 || t_lat !== 3) begin errors++; $display("FAIL bus_err: got err=%b rdata=%h lat=%0d expected 10/0/3", t_err, t_rdata, t_lat); end
  endtask

  task automatic test_timeout;
    do_access(1'b0, 3'b011, 64'h80001010, 64'd0, 5'd13, 64'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (t_err !== 2'b11 || t_rdata !== 64'd0) begin errors++; $display("FAIL timeout_err: got err=%b rdata=%h expected 11/0", t_err, t_rdata); end
    checks++; if (t_lat !== 5 || t_nreq !== 4) begin errors++; $display("FAIL timeout_cycles: got lat=%0d nreq=%0d expected 5/4", t_lat, t_nreq); end
    do_access(1'b0, 3'b011, 64'h80001010, 64'd0, 5'd14, 64'h11223344_55667788, 1'b0, 1'b1, 1'b0);
    checks++; if (t_err !== 2'b00 || t_rdata !== 64'h1122334455667788 || t_rd !== 5'd14) begin errors++; $display("FAIL after_timeout_ld: got err=%b rdata=%h rd=%0d expected 00/1122334455667788/14", t_err, t_rdata, t_rd); end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h80001000; mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;   // REQ, handshake on next edge
    @(negedge clk); mem_req_ready = 1'b0; // WAIT, memory withholds response
    checks++; if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL wait_state: got busy=%b mrv=%b expected 1/0", busy, mem_req_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_in_wait: got busy=%b rv=%b mrv=%b rdy=%b expected 0/0/0/1", busy, resp_valid, mem_req_valid, req_ready); end
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 64'hFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (resp_valid || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL no_resp_after_abort: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back;
    do_access(1'b1, 3'b011, 64'h80002000, 64'hA5A5A5A5_5A5A5A5A, 5'd20, 64'd0, 1'b0, 1'b1, 1'b0);
    do_access(1'b0, 3'b000, 64'h80002007, 64'd0, 5'd21, 64'h7F000000_00000000, 1'b0, 1'b1, 1'b0);
    checks++; if (t_rdy !== 1'b1 || t_lat !== 3) begin errors++; $display("FAIL b2b_accept: got rdy=%b lat=%0d expected 1/3", t_rdy, t_lat); end
    checks++; if (t_rdata !== 64'h000000000000007F || t_rd !== 5'd21) begin errors++; $display("FAIL b2b_rdata: got %h rd=%0d expected 7F/21", t_rdata, t_rd); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; req_rd = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_rdata = '0; mem_resp_err = 1'b0;
    test_reset;
    test_loads;
    test_stores;
    test_illegal;
    test_bus_error;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
